// File: rtl/spi_pixel_loader.sv
// rtl/spi_pixel_loader.sv - SPI byte-stream command parser that writes RGB pixels into frame RAM
module spi_pixel_loader #(
    parameter int NUM_PIXELS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rx_done,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              frame_commit,
    output logic [7:0]        frame_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_PIX    = 3'd3;
    localparam logic [2:0] S_STAT   = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

    localparam logic [7:0] NUM_PIX_B = 8'(NUM_PIXELS);

    logic [2:0]        state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [1:0]        byte_ct_q, byte_ct_d;
    logic [15:0]       acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              badcmd_q, badcmd_d;
    logic              partial_q, partial_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]       wr_data_q, wr_data_d;
    logic              frame_commit_q, frame_commit_d;
    logic [7:0]        frame_count_q, frame_count_d;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        byte_ct_d      = byte_ct_q;
        acc_d          = acc_q;
        ovf_d          = ovf_q;
        badcmd_d       = badcmd_q;
        partial_d      = partial_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        frame_commit_d = 1'b0;
        frame_count_d  = frame_count_q;
        // status word trails the flag flops by one cycle
        tx_byte_d      = {4'hA, 1'b0, partial_q, badcmd_q, ovf_q};

        if (!sel) begin
            state_d   = S_IDLE;
            byte_ct_d = 2'd0;
            acc_d     = 16'd0;
            if (state_q == S_PIX && byte_ct_q != 2'd0) begin
                partial_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_CMD;
                S_CMD: begin
                    if (rx_done) begin
                        case (rx_byte)
                            8'h01: state_d = S_ADDR;
                            8'h02: begin
                                frame_commit_d = 1'b1;
                                frame_count_d  = frame_count_q + 8'd1;
                                state_d        = S_IGNORE;
                            end
                            8'h03: state_d = S_STAT;
                            default: begin
                                badcmd_d = 1'b1;
                                state_d  = S_IGNORE;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (rx_done) begin
                        idx_d     = rx_byte;
                        byte_ct_d = 2'd0;
                        state_d   = S_PIX;
                    end
                end
                S_PIX: begin
                    if (rx_done) begin
                        if (byte_ct_q == 2'd2) begin
                            byte_ct_d = 2'd0;
                            if (idx_q < NUM_PIX_B) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = idx_q[ADDR_W-1:0];
                                wr_data_d = {acc_q, rx_byte};
                            end else begin
                                ovf_d = 1'b1;
                            end
                            // saturate so pixels past the end keep reporting overflow
                            if (idx_q != 8'hFF) begin
                                idx_d = idx_q + 8'd1;
                            end
                        end else begin
                            byte_ct_d = byte_ct_q + 2'd1;
                            acc_d     = {acc_q[7:0], rx_byte};
                        end
                    end
                end
                S_STAT: begin
                    if (rx_done) begin
                        ovf_d     = 1'b0;
                        badcmd_d  = 1'b0;
                        partial_d = 1'b0;
                        state_d   = S_IGNORE;
                    end
                end
                S_IGNORE: state_d = S_IGNORE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= 8'd0;
            byte_ct_q      <= 2'd0;
            acc_q          <= 16'd0;
            ovf_q          <= 1'b0;
            badcmd_q       <= 1'b0;
            partial_q      <= 1'b0;
            tx_byte_q      <= 8'hA0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= 24'd0;
            frame_commit_q <= 1'b0;
            frame_count_q  <= 8'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            byte_ct_q      <= byte_ct_d;
            acc_q          <= acc_d;
            ovf_q          <= ovf_d;
            badcmd_q       <= badcmd_d;
            partial_q      <= partial_d;
            tx_byte_q      <= tx_byte_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            frame_commit_q <= frame_commit_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign tx_byte      = tx_byte_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_commit = frame_commit_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_spi_pixel_loader.sv
// tb/tb_spi_pixel_loader.sv - table, directed and randomized checks for spi_pixel_loader
module tb_spi_pixel_loader;

    localparam int NUM_PIXELS = 64;
    localparam int ADDR_W     = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              sel;
    logic              rx_done;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_byte;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              frame_commit;
    logic [7:0]        frame_count;

    always #5 clk = ~clk;

    spi_pixel_loader #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .sel(sel), .rx_done(rx_done), .rx_byte(rx_byte),
        .tx_byte(tx_byte), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_commit(frame_commit), .frame_count(frame_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // monitor-owned observations
    logic [29:0] act_q[$];
    int          act_commits = 0;
    int          overlap_ct  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) act_q.push_back({wr_addr, wr_data});
            if (frame_commit) act_commits++;
            if (wr_en && frame_commit) overlap_ct++;
        end
    end

    // reference model state
    logic [29:0] exp_q[$];
    logic        m_ovf, m_bad, m_part;
    logic [7:0]  m_fc;
    logic [7:0]  sb [0:15];

    typedef struct {
        int          n;
        logic [95:0] b;
        int          nwr;
        logic [29:0] w0;
        logic [29:0] w1;
        logic [7:0]  tx;
        int          dc;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic run_session(input int n, input int max_gap);
        int gap;
        sel = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < n; i++) begin
            send_byte(sb[i]);
            gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            repeat (gap) tick();
        end
        repeat (2) tick();
        sel = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        sel     = 1'b0;
        rx_done = 1'b0;
        rx_byte = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        m_ovf = 1'b0; m_bad = 1'b0; m_part = 1'b0; m_fc = 8'd0;
    endtask

    // one chip-select session evaluated from the command rules
    task automatic model_session(input int n);
        int idx;
        int npix;
        if (n == 0) return;
        case (sb[0])
            8'h01: begin
                if (n >= 2) begin
                    idx  = int'(sb[1]);
                    npix = (n - 2) / 3;
                    for (int k = 0; k < npix; k++) begin
                        if (idx < NUM_PIXELS) exp_q.push_back({6'(idx), sb[2+3*k], sb[3+3*k], sb[4+3*k]});
                        else m_ovf = 1'b1;
                        if (idx < 255) idx++;
                    end
                    if ((n - 2) % 3 != 0) m_part = 1'b1;
                end
            end
            8'h02: m_fc = m_fc + 8'd1;
            8'h03: begin
                if (n >= 2) begin
                    m_ovf = 1'b0; m_bad = 1'b0; m_part = 1'b0;
                end
            end
            default: m_bad = 1'b1;
        endcase
    endtask

    initial begin
        int base_wr, base_cm, got, act_rd, exp_rd, ncmd, cm0, n;
        logic [7:0] cmd;

        vt[0]  = '{8,  96'h010503FF0011223344_000000 >> 8, 2, {6'd5, 24'hFF0011}, {6'd6, 24'h223344}, 8'hA0, 0};
        vt[0].b = 96'h0105FF0011223344_00000000;
        vt[1]  = '{8,  96'h013F102030405060_00000000, 1, {6'd63, 24'h102030}, 30'd0, 8'hA1, 0};
        vt[2]  = '{2,  96'h0300_00000000000000000000, 0, 30'd0, 30'd0, 8'hA0, 0};
        vt[3]  = '{4,  96'h0100AABB_0000000000000000, 0, 30'd0, 30'd0, 8'hA4, 0};
        vt[4]  = '{2,  96'h0300_00000000000000000000, 0, 30'd0, 30'd0, 8'hA0, 0};
        vt[5]  = '{1,  96'h02_0000000000000000000000, 0, 30'd0, 30'd0, 8'hA0, 1};
        vt[6]  = '{5,  96'h7E01051122_00000000000000, 0, 30'd0, 30'd0, 8'hA2, 0};
        vt[7]  = '{11, 96'h013E010203040506070809_00, 2, {6'd62, 24'h010203}, {6'd63, 24'h040506}, 8'hA3, 0};
        vt[8]  = '{2,  96'h0300_00000000000000000000, 0, 30'd0, 30'd0, 8'hA0, 0};
        vt[9]  = '{8,  96'h01FF010203040506_00000000, 0, 30'd0, 30'd0, 8'hA1, 0};
        vt[10] = '{3,  96'h011077_000000000000000000, 0, 30'd0, 30'd0, 8'hA5, 0};
        vt[11] = '{3,  96'h030055_000000000000000000, 0, 30'd0, 30'd0, 8'hA0, 0};

        do_reset();
        check("t1_tx_byte", 32'(tx_byte), 32'hA0);
        check("t1_wr_en", 32'(wr_en), 32'd0);
        check("t1_frame_commit", 32'(frame_commit), 32'd0);
        check("t1_frame_count", 32'(frame_count), 32'd0);
        check("t1_wr_addr", 32'(wr_addr), 32'd0);
        check("t1_wr_data", 32'(wr_data), 32'd0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < vt[r].n; i++) sb[i] = vt[r].b[95-8*i -: 8];
            base_wr = act_q.size();
            base_cm = act_commits;
            run_session(vt[r].n, r % 2);
            got = act_q.size() - base_wr;
            check($sformatf("row%0d_nwr", r), 32'(got), 32'(vt[r].nwr));
            if (vt[r].nwr >= 1 && got >= 1) check($sformatf("row%0d_w0", r), 32'(act_q[base_wr]), 32'(vt[r].w0));
            if (vt[r].nwr >= 2 && got >= 2) check($sformatf("row%0d_w1", r), 32'(act_q[base_wr+1]), 32'(vt[r].w1));
            check($sformatf("row%0d_tx", r), 32'(tx_byte), 32'(vt[r].tx));
            check($sformatf("row%0d_commits", r), 32'(act_commits - base_cm), 32'(vt[r].dc));
        end

        // one-cycle latency of the write and commit strobes
        sel = 1'b1;
        repeat (2) tick();
        send_byte(8'h01);
        send_byte(8'h08);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        check("lat_wr_en", 32'(wr_en), 32'd1);
        check("lat_wr_addr", 32'(wr_addr), 32'd8);
        check("lat_wr_data", 32'(wr_data), 32'hAABBCC);
        check("lat_commit_low", 32'(frame_commit), 32'd0);
        tick();
        check("lat_wr_en_drop", 32'(wr_en), 32'd0);
        sel = 1'b0;
        repeat (2) tick();
        sel = 1'b1;
        repeat (2) tick();
        cm0 = int'(frame_count);
        send_byte(8'h02);
        check("lat_commit", 32'(frame_commit), 32'd1);
        check("lat_commit_wr_low", 32'(wr_en), 32'd0);
        check("lat_count", 32'(frame_count), 32'((cm0 + 1) % 256));
        tick();
        check("lat_commit_drop", 32'(frame_commit), 32'd0);
        sel = 1'b0;
        repeat (3) tick();

        // randomized sessions against the model
        do_reset();
        exp_q.delete();
        act_rd = act_q.size();
        exp_rd = 0;
        cm0 = act_commits;
        ncmd = 0;
        for (int s = 0; s < 80; s++) begin
            int r;
            r = $urandom_range(9, 0);
            cmd = (r < 6) ? 8'h01 : (r == 6) ? 8'h02 : (r == 7) ? 8'h03 : 8'($urandom_range(255, 0));
            for (int i = 0; i < 16; i++) sb[i] = 8'($urandom_range(255, 0));
            sb[0] = cmd;
            if (cmd == 8'h01) begin
                sb[1] = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 0)) : 8'($urandom_range(70, 56));
                n = 2 + $urandom_range(10, 0);
                if ($urandom_range(7, 0) == 0) n = 1;
            end else begin
                n = $urandom_range(3, 1);
            end
            if (cmd == 8'h02) ncmd++;
            model_session(n);
            run_session(n, 2);
            check($sformatf("rnd%0d_nwr", s), 32'(act_q.size() - act_rd), 32'(exp_q.size() - exp_rd));
            while (act_rd < act_q.size() && exp_rd < exp_q.size()) begin
                check($sformatf("rnd%0d_write", s), 32'(act_q[act_rd]), 32'(exp_q[exp_rd]));
                act_rd++;
                exp_rd++;
            end
            act_rd = act_q.size();
            exp_rd = exp_q.size();
            check($sformatf("rnd%0d_tx", s), 32'(tx_byte), 32'({4'hA, 1'b0, m_part, m_bad, m_ovf}));
            check($sformatf("rnd%0d_fc", s), 32'(frame_count), 32'(m_fc));
        end
        check("rnd_commit_pulses", 32'(act_commits - cm0), 32'(ncmd));
        check("rnd_no_overlap", 32'(overlap_ct), 32'd0);

        // commit counting and wrap
        do_reset();
        sb[0] = 8'h02;
        for (int i = 0; i < 3; i++) run_session(1, 0);
        check("t5_count3", 32'(frame_count), 32'd3);
        for (int i = 0; i < 253; i++) run_session(1, 0);
        check("t5_wrap", 32'(frame_count), 32'd0);
        run_session(1, 0);
        check("t5_after_wrap", 32'(frame_count), 32'd1);

        // bad command, then reset in the middle of a pixel
        sb[0] = 8'h7E; sb[1] = 8'h01; sb[2] = 8'h05; sb[3] = 8'h11; sb[4] = 8'h22; sb[5] = 8'h33; sb[6] = 8'h44;
        base_wr = act_q.size();
        run_session(7, 0);
        check("t6_badcmd_tx", 32'(tx_byte), 32'hA2);
        check("t6_ignored", 32'(act_q.size() - base_wr), 32'd0);
        sel = 1'b1;
        repeat (2) tick();
        send_byte(8'h01);
        send_byte(8'h07);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        rst = 1'b1;
        tick();
        check("t6_rst_tx", 32'(tx_byte), 32'hA0);
        check("t6_rst_wr_en", 32'(wr_en), 32'd0);
        check("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("t6_rst_wr_data", 32'(wr_data), 32'd0);
        check("t6_rst_commit", 32'(frame_commit), 32'd0);
        check("t6_rst_count", 32'(frame_count), 32'd0);
        rst = 1'b0;
        sel = 1'b0;
        repeat (3) tick();
        check("t6_idle_tx", 32'(tx_byte), 32'hA0);
        check("final_no_overlap", 32'(overlap_ct), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
